// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array operand path.
package sa_pkg;

    localparam int unsigned SA_DIM = 4;
    localparam int unsigned SA_DW  = 8;
    localparam int unsigned IDX_W  = $clog2(SA_DIM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM,
        ST_WAIT,
        ST_DONE
    } sa_ld_state_t;

    // One matrix row or column; element j sits in bits [8j+7:8j].
    typedef logic [SA_DIM-1:0][SA_DW-1:0] sa_row_t;

endpackage

// File: rtl/sa_operand_buf.sv
// 4x4 byte operand buffer: row-wide writes, row or column reads.
module sa_operand_buf
    import sa_pkg::*;
#(
    parameter bit READ_COL = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_row,
    input  sa_row_t          wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output sa_row_t          rd_data_c
);

    sa_row_t mem_q [SA_DIM];

    // Row write port; reset clears the whole matrix.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < int'(SA_DIM); r++) begin
                mem_q[r] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_row] <= wr_data;
        end
    end

    if (READ_COL) begin : g_col
        // Column k gathered top to bottom: lane r = element [r][k].
        always_comb begin
            rd_data_c = '0;
            for (int r = 0; r < int'(SA_DIM); r++) begin
                rd_data_c[r] = mem_q[r][rd_idx];
            end
        end
    end else begin : g_row
        // Row k returned as stored.
        always_comb begin
            rd_data_c = mem_q[rd_idx];
        end
    end

endmodule

// File: rtl/sa_operand_loader.sv
// Fetches A/B operand matrices from SRAM and streams them skewed into the array.
module sa_operand_loader
    import sa_pkg::*;
#(
    parameter int unsigned AW             = 8,
    parameter int unsigned COMPUTE_CYCLES = 23
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    output logic          busy,
    output logic          done,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    output logic          sa_en,
    output logic [7:0]    sa_a0,
    output logic [7:0]    sa_a1,
    output logic [7:0]    sa_a2,
    output logic [7:0]    sa_a3,
    output logic [7:0]    sa_b0,
    output logic [7:0]    sa_b1,
    output logic [7:0]    sa_b2,
    output logic [7:0]    sa_b3
);

    localparam int unsigned CNT_MAX = (COMPUTE_CYCLES > 9) ? COMPUTE_CYCLES : 9;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] FETCH_LAST  = CNT_W'(8);
    localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(4);
    localparam logic [CNT_W-1:0] WAIT_LAST   =
        CNT_W'((COMPUTE_CYCLES == 0) ? 0 : COMPUTE_CYCLES - 1);

    sa_ld_state_t     state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [AW-1:0]    a_base_q, a_base_n, b_base_q, b_base_n;

    logic             busy_n, done_n, mem_rd_n, sa_en_n, beat_n;
    logic [AW-1:0]    mem_addr_n;
    logic [IDX_W-1:0] rd_idx_c, wr_row_c;
    logic             a_wr_c, b_wr_c;
    sa_row_t          a_col_c, b_row_c;

    // State, phase counter and latched bases.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            a_base_q <= a_base_n;
            b_base_q <= b_base_n;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        a_base_n = a_base_q;
        b_base_n = b_base_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n  = ST_FETCH;
                    cnt_n    = '0;
                    a_base_n = a_base;
                    b_base_n = b_base;
                end
            end
            ST_FETCH: begin
                if (cnt_q == FETCH_LAST) begin
                    state_n = ST_STREAM;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_STREAM: begin
                if (cnt_q == STREAM_LAST) begin
                    state_n = (COMPUTE_CYCLES == 0) ? ST_DONE : ST_WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_n = ST_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        busy_n     = (state_n != ST_IDLE);
        done_n     = (state_n == ST_DONE);
        mem_rd_n   = (state_n == ST_FETCH) && (cnt_n != FETCH_LAST);
        // Reads 0..3 hit A rows, 4..7 hit B rows; bit 2 picks the matrix.
        mem_addr_n = '0;
        if (mem_rd_n) begin
            mem_addr_n = (cnt_n[2] ? b_base_n : a_base_n) + AW'(cnt_n[1:0]);
        end
        sa_en_n    = (state_n == ST_STREAM) && (cnt_n != STREAM_LAST);
        beat_n     = (state_n == ST_STREAM) && (cnt_n != '0);
        // Beat i = s-1 uses index 3-i = 4-s.
        rd_idx_c   = IDX_W'(3'd4 - cnt_n[2:0]);
    end

    // Capture the read return one cycle after each strobe.
    always_comb begin
        a_wr_c   = (state_q == ST_FETCH) && (cnt_q != '0) && (cnt_q <= CNT_W'(4));
        b_wr_c   = (state_q == ST_FETCH) && (cnt_q >  CNT_W'(4));
        wr_row_c = IDX_W'(cnt_q - CNT_W'(1));
    end

    sa_operand_buf #(.READ_COL(1'b1)) u_buf_a (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (a_wr_c),
        .wr_row   (wr_row_c),
        .wr_data  (mem_rdata),
        .rd_idx   (rd_idx_c),
        .rd_data_c(a_col_c)
    );

    sa_operand_buf #(.READ_COL(1'b0)) u_buf_b (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (b_wr_c),
        .wr_row   (wr_row_c),
        .wr_data  (mem_rdata),
        .rd_idx   (rd_idx_c),
        .rd_data_c(b_row_c)
    );

    // Output registers; lanes are zero outside beat cycles.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            sa_en    <= 1'b0;
            sa_a0    <= '0;
            sa_a1    <= '0;
            sa_a2    <= '0;
            sa_a3    <= '0;
            sa_b0    <= '0;
            sa_b1    <= '0;
            sa_b2    <= '0;
            sa_b3    <= '0;
        end else begin
            busy     <= busy_n;
            done     <= done_n;
            mem_rd   <= mem_rd_n;
            mem_addr <= mem_addr_n;
            sa_en    <= sa_en_n;
            sa_a0    <= beat_n ? a_col_c[0] : '0;
            sa_a1    <= beat_n ? a_col_c[1] : '0;
            sa_a2    <= beat_n ? a_col_c[2] : '0;
            sa_a3    <= beat_n ? a_col_c[3] : '0;
            sa_b0    <= beat_n ? b_row_c[0] : '0;
            sa_b1    <= beat_n ? b_row_c[1] : '0;
            sa_b2    <= beat_n ? b_row_c[2] : '0;
            sa_b3    <= beat_n ? b_row_c[3] : '0;
        end
    end

endmodule

// File: tb/tb_sa_operand_loader.sv
// Bench for sa_operand_loader: default build plus a COMPUTE_CYCLES=0 build.
module tb_sa_operand_loader;

    localparam int CC = 23;
    localparam int P  = 16 + CC;

    logic        clk = 1'b0;
    logic        rstn, start, start0;
    logic [7:0]  a_base, b_base;

    logic        busy, done, mem_rd, sa_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [7:0]  sa_a0, sa_a1, sa_a2, sa_a3, sa_b0, sa_b1, sa_b2, sa_b3;

    logic        busy0, done0, mem_rd0, sa_en0;
    logic [7:0]  mem_addr0;
    logic [31:0] mem_rdata0;
    logic [7:0]  sa0_a0, sa0_a1, sa0_a2, sa0_a3, sa0_b0, sa0_b1, sa0_b2, sa0_b3;

    logic [31:0] mem [256];
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    sa_operand_loader #(.AW(8), .COMPUTE_CYCLES(CC)) dut (
        .clk(clk), .rstn(rstn), .start(start), .a_base(a_base), .b_base(b_base),
        .busy(busy), .done(done), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .sa_en(sa_en),
        .sa_a0(sa_a0), .sa_a1(sa_a1), .sa_a2(sa_a2), .sa_a3(sa_a3),
        .sa_b0(sa_b0), .sa_b1(sa_b1), .sa_b2(sa_b2), .sa_b3(sa_b3)
    );

    sa_operand_loader #(.AW(8), .COMPUTE_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .a_base(a_base), .b_base(b_base),
        .busy(busy0), .done(done0), .mem_rd(mem_rd0), .mem_addr(mem_addr0),
        .mem_rdata(mem_rdata0), .sa_en(sa_en0),
        .sa_a0(sa0_a0), .sa_a1(sa0_a1), .sa_a2(sa0_a2), .sa_a3(sa0_a3),
        .sa_b0(sa0_b0), .sa_b1(sa0_b1), .sa_b2(sa0_b2), .sa_b3(sa0_b3)
    );

    // SRAM models: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) mem_rdata  <= mem_rd  ? mem[mem_addr]  : $urandom;
    always @(posedge clk) mem_rdata0 <= mem_rd0 ? mem[mem_addr0] : $urandom;

    function automatic logic [75:0] act_main();
        return {busy, done, mem_rd, mem_addr, sa_en,
                sa_a0, sa_a1, sa_a2, sa_a3, sa_b0, sa_b1, sa_b2, sa_b3};
    endfunction

    function automatic logic [75:0] act_zero();
        return {busy0, done0, mem_rd0, mem_addr0, sa_en0,
                sa0_a0, sa0_a1, sa0_a2, sa0_a3, sa0_b0, sa0_b1, sa0_b2, sa0_b3};
    endfunction

    // Reference: outputs at cycle offset `off` after a start sampled at offset 0.
    function automatic logic [75:0] exp_out(input int off, input int cc,
                                            input logic [7:0] ab, input logic [7:0] bb);
        logic       b_e = 1'b0, d_e = 1'b0, r_e = 1'b0, en_e = 1'b0;
        logic [7:0] ad_e = '0;
        logic [7:0] la [4];
        logic [7:0] lb [4];
        logic [31:0] w;
        int i;
        for (int k = 0; k < 4; k++) begin
            la[k] = '0;
            lb[k] = '0;
        end
        if (off >= 1 && off <= 15 + cc) b_e = 1'b1;
        if (off == 15 + cc) d_e = 1'b1;
        if (off >= 1 && off <= 8) begin
            r_e  = 1'b1;
            ad_e = (off <= 4) ? 8'(int'(ab) + off - 1) : 8'(int'(bb) + off - 5);
        end
        if (off >= 10 && off <= 13) en_e = 1'b1;
        if (off >= 11 && off <= 14) begin
            i = off - 11;
            for (int r = 0; r < 4; r++) begin
                w     = mem[8'(int'(ab) + r)];
                la[r] = w[8*(3-i) +: 8];
            end
            w = mem[8'(int'(bb) + 3 - i)];
            for (int c = 0; c < 4; c++) lb[c] = w[8*c +: 8];
        end
        return {b_e, d_e, r_e, ad_e, en_e, la[0], la[1], la[2], la[3],
                lb[0], lb[1], lb[2], lb[3]};
    endfunction

    task automatic set_rows(input logic [7:0] base, input logic [31:0] r0,
                            input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3);
        mem[base]          = r0;
        mem[8'(base + 1)]  = r1;
        mem[8'(base + 2)]  = r2;
        mem[8'(base + 3)]  = r3;
    endtask

    // mode 0: single clean job; 1: random extra starts and base changes while busy;
    // 2: start held high for two back-to-back jobs.
    task automatic run_job(input logic [7:0] ab, input logic [7:0] bb, input int mode,
                           input string name, output logic [63:0] beat0,
                           output logic [63:0] beat1, output logic [63:0] beat3,
                           output int done_cyc);
        int ncyc = (mode == 2) ? 2 * P : P + 2;
        int reads = 0, dones = 0, off;
        logic [75:0] a, e;
        done_cyc = -1;
        beat0 = '0; beat1 = '0; beat3 = '0;
        a_base = ab;
        b_base = bb;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            off = (mode == 2) ? (c % P) : c;
            a = act_main();
            e = exp_out(off, CC, ab, bb);
            total++;
            if (a !== e) $display("FAIL %s cycle %0d: got %h expected %h", name, c, a, e);
            else passed++;
            reads += int'(mem_rd);
            if (done === 1'b1) begin
                dones++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 11) beat0 = a[63:0];
            if (c == 12) beat1 = a[63:0];
            if (c == 14) beat3 = a[63:0];
            case (mode)
                1: begin
                    start = (c <= P - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    a_base = 8'($urandom);
                    b_base = 8'($urandom);
                end
                2: start = (c < 2 * P) ? 1'b1 : 1'b0;
                default: start = 1'b0;
            endcase
        end
        start = 1'b0;
        total++;
        if (reads != ((mode == 2) ? 16 : 8)) $display("FAIL %s read_count: got %0d", name, reads);
        else passed++;
        total++;
        if (dones != ((mode == 2) ? 2 : 1)) $display("FAIL %s done_count: got %0d", name, dones);
        else passed++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b0;
        start0 = 1'b0;
        a_base = 8'h5A;
        b_base = 8'hA5;
        repeat (3) @(negedge clk);
        total++;
        if (act_main() !== 76'd0) $display("FAIL reset_main: got %h expected 0", act_main());
        else passed++;
        total++;
        if (act_zero() !== 76'd0) $display("FAIL reset_cc0: got %h expected 0", act_zero());
        else passed++;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_plan_ramp();
        logic [63:0] b0, b1, b3;
        int dc;
        set_rows(8'h10, 32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201);
        set_rows(8'h20, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
        run_job(8'h10, 8'h20, 0, "ramp", b0, b1, b3, dc);
        total++;
        if (b0 !== 64'h04040404_04040404) $display("FAIL ramp_beat0: got %h expected %h", b0, 64'h0404040404040404);
        else passed++;
        total++;
        if (b3 !== 64'h01010101_01010101) $display("FAIL ramp_beat3: got %h expected %h", b3, 64'h0101010101010101);
        else passed++;
        total++;
        if (dc != 38) $display("FAIL ramp_done_cycle: got %0d expected 38", dc);
        else passed++;
    endtask

    task automatic test_border();
        logic [63:0] b0, b1, b3;
        logic [31:0] er [4];
        int dc;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) er[i][8*j +: 8] = 8'(2 * (4 * i + j) + 12);
        set_rows(8'hFE, 32'h01010101, 32'h01000001, 32'h01000001, 32'h01010101);
        set_rows(8'h40, er[0], er[1], er[2], er[3]);
        run_job(8'hFE, 8'h40, 0, "border", b0, b1, b3, dc);
        total++;
        if (b0 !== {8'd1, 8'd1, 8'd1, 8'd1, 8'd36, 8'd38, 8'd40, 8'd42})
            $display("FAIL border_beat0: got %h", b0);
        else passed++;
        total++;
        if (b1 !== {8'd1, 8'd0, 8'd0, 8'd1, 8'd28, 8'd30, 8'd32, 8'd34})
            $display("FAIL border_beat1: got %h", b1);
        else passed++;
    endtask

    task automatic test_gh();
        logic [63:0] b0, b1, b3;
        logic [31:0] gr [4];
        logic [31:0] hr [4];
        int dc;
        for (int i = 0; i < 4; i++) begin
            hr[i] = '0;
            for (int j = 0; j < 4; j++) gr[i][8*j +: 8] = 8'(3 * (4 * i + j));
            hr[i][8*i +: 8]     = 8'd2;
            hr[i][8*(3-i) +: 8] = 8'd1;
        end
        set_rows(8'h60, gr[0], gr[1], gr[2], gr[3]);
        set_rows(8'h70, hr[0], hr[1], hr[2], hr[3]);
        run_job(8'h60, 8'h70, 0, "gh", b0, b1, b3, dc);
        total++;
        if (b0 !== {8'd9, 8'd21, 8'd33, 8'd45, 8'd1, 8'd0, 8'd0, 8'd2})
            $display("FAIL gh_beat0: got %h", b0);
        else passed++;
    endtask

    task automatic test_extra_starts();
        logic [63:0] b0, b1, b3;
        int dc;
        for (int k = 0; k < 256; k++) mem[k] = $urandom;
        run_job(8'h33, 8'hC7, 1, "extra_starts", b0, b1, b3, dc);
    endtask

    task automatic test_back_to_back();
        logic [63:0] b0, b1, b3;
        int dc;
        run_job(8'h80, 8'h08, 2, "back_to_back", b0, b1, b3, dc);
    endtask

    task automatic test_reset_mid();
        logic [63:0] b0, b1, b3;
        int dc, dones = 0;
        a_base = 8'h11;
        b_base = 8'h22;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rstn = 1'b0;
        for (int c = 13; c <= P + 4; c++) begin
            @(negedge clk);
            if (c == 13 || c == P + 4) begin
                total++;
                if (act_main() !== 76'd0) $display("FAIL reset_mid cycle %0d: got %h expected 0", c, act_main());
                else passed++;
            end
            dones += int'(done);
            rstn = 1'b1;
        end
        total++;
        if (dones != 0) $display("FAIL reset_mid_no_done: got %0d expected 0", dones);
        else passed++;
        run_job(8'h11, 8'h22, 0, "after_reset", b0, b1, b3, dc);
    endtask

    task automatic test_cc0();
        logic [75:0] a, e;
        int fall = -1;
        a_base = 8'h90;
        b_base = 8'hB0;
        @(negedge clk);
        start0 = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            a = act_zero();
            e = exp_out(c, 0, 8'h90, 8'hB0);
            total++;
            if (a !== e) $display("FAIL cc0 cycle %0d: got %h expected %h", c, a, e);
            else passed++;
            if (fall < 0 && c > 1 && busy0 === 1'b0) fall = c;
        end
        total++;
        if (fall != 16) $display("FAIL cc0_busy_fall: got %0d expected 16", fall);
        else passed++;
    endtask

    task automatic test_random();
        logic [63:0] b0, b1, b3;
        int dc;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 256; k++) mem[k] = $urandom;
            run_job(8'($urandom), 8'($urandom), 0, "random", b0, b1, b3, dc);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = '0;
        test_reset();
        test_plan_ramp();
        test_border();
        test_gh();
        test_extra_starts();
        test_back_to_back();
        test_reset_mid();
        test_cc0();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sa_operand_loader.md
# sa_operand_loader

Upstream feeder for `systolic_array_wrapper`. On a host `start`, it reads a 4×4 left matrix A and a 4×4 right matrix B (8-bit elements, row-major, one row per 32-bit word) from operand SRAM. It buffers them, then drives the wrapper's `en` and `shift_in_A_*`/`shift_in_B_*` lanes in the required 4-beat skew order. It then holds off for the array's compute/drain window and pulses `done`.

## Interface
- `AW`, 8: SRAM word address width.
- `COMPUTE_CYCLES`, 23: idle cycles after the last beat before `done`, covering array compute plus output drain.
- `clk`  in  1: clock.
- `rstn`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start`  in  1: job request, sampled only in IDLE.
- `a_base`  in  AW: word address of A row 0; rows 1..3 are at +1..+3.
- `b_base`  in  AW: word address of B row 0; rows 1..3 are at +1..+3.
- `busy`  out  1: high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1: one-cycle pulse at job end.
- `mem_rd`  out  1: SRAM read strobe.
- `mem_addr`  out  AW: SRAM read address.
- `mem_rdata`  in  32: read data, valid exactly 1 cycle after `mem_rd`. Byte j = `[8j+7:8j]` holds column j.
- `sa_en`  out  1: drives wrapper `en`.
- `sa_a0`..`sa_a3`  out  8 each: drive `shift_in_A_0..3`.
- `sa_b0`..`sa_b3`  out  8 each: drive `shift_in_B_0..3`.

## Operation
- States: IDLE, FETCH, STREAM, WAIT, DONE.
- IDLE: if `start` is high, latch `a_base`/`b_base` and go to FETCH. Otherwise stay in IDLE.
- FETCH, 9 cycles:
  - Cycles f=0..7 issue reads: `mem_rd`=1, `mem_addr` = `a_base`+f for f<4, `b_base`+(f-4) otherwise.
  - Cycles f=1..8 capture `mem_rdata` into the row buffer: A row f-1 or B row f-5.
  - Cycle 8 has no read and is the final capture.
- STREAM, 5 cycles, s=0..4:
  - `sa_en`=1 for s=0..3.
  - Beat i=s-1 is presented on s=1..4:
    - `sa_a<r>` = A[r][3-i]: column 3-i of A, top to bottom.
    - `sa_b<c>` = B[3-i][c]: row 3-i of B.
  - Data therefore lags `sa_en` by exactly one cycle.
- WAIT: count `COMPUTE_CYCLES` cycles, with all `sa_*` = 0.
- DONE: 1 cycle, `done`=1, then IDLE.
- Outside beat cycles, all `sa_a*`/`sa_b*` = 0 and `sa_en` = 0. All `sa_*` outputs are registered.
- `start` is ignored while `busy`. `start` held high in the DONE cycle is not accepted; it is accepted in the following IDLE cycle.
- Elements are passed through unsigned, with no arithmetic and no width change.
- `COMPUTE_CYCLES`=0 is legal: WAIT is skipped and DONE follows STREAM.

## Timing
- Reset (`rstn`=0 at an edge): state becomes IDLE, and the counter, latched bases and buffers are cleared. All outputs are 0: `busy`, `done`, `mem_rd`, `mem_addr`, `sa_en`, `sa_a*`, `sa_b*`.
- Reset mid-job aborts immediately. No `done` is issued, and outputs are 0 the cycle after the reset edge.
- `start` sampled high at cycle 0 gives the following schedule:
  - FETCH: cycles 1–9, with reads on cycles 1–8.
  - `sa_en`: cycles 10–13.
  - Beats 0–3: cycles 11–14.
  - WAIT: cycles 15 to 14+`COMPUTE_CYCLES`.
  - `done`: cycle 15+`COMPUTE_CYCLES`, which is cycle 38 at the default.
  - Next `start` is accepted at cycle 16+`COMPUTE_CYCLES` at the earliest.
- `busy` = 1 on cycles 1 through the `done` cycle inclusive.

## Structure
- Shared package `sa_pkg`:
  - `SA_DIM`=4, `SA_DW`=8.
  - State enum `sa_ld_state_t`.
  - Type `sa_row_t`, an array of 4 bytes.
- Sub-module `sa_operand_buf`, instantiated twice (A and B):
  - 4×4 byte register file.
  - Row write port: row index plus 32-bit word.
  - Column read port for A, returning 4 bytes of column k.
  - Row read port for B, returning 4 bytes of row k.
- Top level contains the FSM, the cycle counter, address generation and the output registers.

## Test plan
- **A rows = 0x04030201 ×4, B row i = (i+1)×0x01010101, start at cycle 0:**
  - 8 reads, addresses a_base..+3 then b_base..+3.
  - Beat 0 is cycle 11: all A lanes 4, all B lanes 4.
  - Beat 3: all A lanes 1, all B lanes 1.
  - `done` at cycle 38.
- **D (1-border/0-interior) with E[i][j] = 2(4i+j)+12:**
  - Beat 0: A lanes 1,1,1,1; B lanes 36,38,40,42.
  - Beat 1: A lanes 1,0,0,1; B lanes 28,30,32,34.
- **Extra `start` pulses during FETCH, STREAM and WAIT:**
  - Ignored; exactly one `done`; read count is 8.
  - `start` held high continuously produces back-to-back jobs, with FETCH starting in the cycle after IDLE.
- **`rstn`=0 on cycle 12 (mid-STREAM):**
  - The next cycle has all outputs 0 and state IDLE; no `done`.
  - A new `start` then runs the full schedule correctly.
- **`COMPUTE_CYCLES`=0 build:** `done` at cycle 15; `busy` falls at cycle 16.
- **G/H case (G[i][j] = 3(4i+j), H = 2-diagonal/1-anti-diagonal):**
  - Beat 0: A lanes 9,21,33,45; B lanes 1,0,0,2.
